// File: rtl/e_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline family.
package e_pipe_pkg;

    localparam int unsigned MAX_DEPTH = 64;

    // Bits needed to hold values 0..n (occupancy counter width).
    function automatic int unsigned clog2_plus1(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((n >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/e_elastic_delay_if.sv
// Handshake bundle for e_elastic_delay: input side, output side, flush and occupancy.
interface e_elastic_delay_if
    import e_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) ();
    localparam int unsigned CNT_W = clog2_plus1(DEPTH);

    logic [WIDTH-1:0] in_data_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] out_data_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             flush_i;
    logic [CNT_W-1:0] count_o;

    modport master (
        output in_data_i, in_valid_i, out_ready_i, flush_i,
        input  in_ready_o, out_data_o, out_valid_o, count_o
    );

    modport slave (
        input  in_data_i, in_valid_i, out_ready_i, flush_i,
        output in_ready_o, out_data_o, out_valid_o, count_o
    );
endinterface

// File: rtl/e_elastic_stage.sv
// One valid+data slice of the elastic pipeline; data only captures valid words.
module e_elastic_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             i_load,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_flush)     r_valid <= 1'b0;
            else if (i_load) r_valid <= i_valid;
            if (i_load && i_valid) r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/e_elastic_delay.sv
// DEPTH-stage elastic delay line with bubble-collapsing ready chain, flush and occupancy count.
module e_elastic_delay
    import e_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = clog2_plus1(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    e_elastic_delay_if.slave  bus
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    logic [DEPTH-1:0] w_v;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic [DEPTH-1:0] w_mv;
    stage_t           w_in [DEPTH];
    logic             w_acc;
    logic             w_out_hs;
    logic [CNT_W-1:0] r_count;

    // Unrolled ready chain: stage k may move if the consumer is ready or any
    // stage at or after k holds a bubble.
    always_comb begin : p_ready
        logic w_full;
        w_mv = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_full = 1'b1;
            for (int unsigned j = k; j < DEPTH; j++) w_full = w_full & w_v[j];
            w_mv[k] = !w_full || bus.out_ready_i;
        end
    end

    always_comb begin
        w_in[0] = '{valid: bus.in_valid_i, data: bus.in_data_i};
        for (int unsigned k = 1; k < DEPTH; k++) begin
            w_in[k] = '{valid: w_v[k-1], data: w_d[k-1]};
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        e_elastic_stage #(.WIDTH(WIDTH)) u_stage (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .i_load  (w_mv[g]),
            .i_flush (bus.flush_i),
            .i_valid (w_in[g].valid),
            .i_data  (w_in[g].data),
            .o_valid (w_v[g]),
            .o_data  (w_d[g])
        );
    end

    assign w_acc    = bus.in_valid_i && w_mv[0];
    assign w_out_hs = w_v[DEPTH-1] && bus.out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)         r_count <= '0;
        else if (bus.flush_i) r_count <= '0;
        else                  r_count <= r_count + CNT_W'(w_acc) - CNT_W'(w_out_hs);
    end

    assign bus.in_ready_o  = w_mv[0];
    assign bus.out_valid_o = w_v[DEPTH-1];
    assign bus.out_data_o  = w_d[DEPTH-1];
    assign bus.count_o     = r_count;
endmodule

// File: tb/tb_e_elastic_delay.sv
// Directed and seeded-random checks of e_elastic_delay at DEPTH=3/W8, DEPTH=1/W32, DEPTH=8/W32.
module tb_e_elastic_delay;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    e_elastic_delay_if #(.WIDTH(8),  .DEPTH(3)) if3 ();
    e_elastic_delay_if #(.WIDTH(32), .DEPTH(1)) if1 ();
    e_elastic_delay_if #(.WIDTH(32), .DEPTH(8)) if8 ();

    e_elastic_delay #(.WIDTH(8),  .DEPTH(3)) dut3 (.clk_i(clk), .rst_n_i(rst_n), .bus(if3.slave));
    e_elastic_delay #(.WIDTH(32), .DEPTH(1)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(if1.slave));
    e_elastic_delay #(.WIDTH(32), .DEPTH(8)) dut8 (.clk_i(clk), .rst_n_i(rst_n), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", if3.out_valid_o); end
        tests_run++; if (if3.out_data_o !== 8'h00) begin tests_failed++; $display("FAIL rst_data: got %h want 00", if3.out_data_o); end
        tests_run++; if (if3.count_o !== 2'd0) begin tests_failed++; $display("FAIL rst_count: got %0d want 0", if3.count_o); end
        tests_run++; if (if3.in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b want 1", if3.in_ready_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency;
        @(negedge clk);
        if3.out_ready_i = 1'b1; if3.in_valid_i = 1'b1; if3.in_data_i = 8'h01;
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL lat_e1_valid: got %b want 0", if3.out_valid_o); end
        tests_run++; if (if3.count_o !== 2'd1) begin tests_failed++; $display("FAIL lat_e1_count: got %0d want 1", if3.count_o); end
        if3.in_data_i = 8'h00;
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL lat_e2_valid: got %b want 0", if3.out_valid_o); end
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b1) begin tests_failed++; $display("FAIL lat_e3_valid: got %b want 1", if3.out_valid_o); end
        tests_run++; if (if3.out_data_o !== 8'h01) begin tests_failed++; $display("FAIL lat_e3_data: got %h want 01", if3.out_data_o); end
        tests_run++; if (if3.count_o !== 2'd3) begin tests_failed++; $display("FAIL lat_e3_count: got %0d want 3", if3.count_o); end
        @(negedge clk);
        tests_run++; if (if3.out_data_o !== 8'h00) begin tests_failed++; $display("FAIL lat_e4_data: got %h want 00", if3.out_data_o); end
        tests_run++; if (if3.count_o !== 2'd3) begin tests_failed++; $display("FAIL lat_e4_count: got %0d want 3", if3.count_o); end
        @(negedge clk);
        tests_run++; if (if3.count_o !== 2'd3) begin tests_failed++; $display("FAIL lat_e5_count: got %0d want 3", if3.count_o); end
        if3.in_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (if3.count_o !== 2'd0) begin tests_failed++; $display("FAIL lat_drain_count: got %0d want 0", if3.count_o); end
        tests_run++; if (if3.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL lat_drain_valid: got %b want 0", if3.out_valid_o); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        if3.out_ready_i = 1'b0; if3.in_valid_i = 1'b1; if3.in_data_i = 8'h10;
        @(negedge clk); if3.in_data_i = 8'h11;
        @(negedge clk); if3.in_data_i = 8'h12;
        @(negedge clk); if3.in_data_i = 8'h13;
        #1;
        tests_run++; if (if3.in_ready_o !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_full: got %b want 0", if3.in_ready_o); end
        tests_run++; if (if3.count_o !== 2'd3) begin tests_failed++; $display("FAIL bp_count_full: got %0d want 3", if3.count_o); end
        @(negedge clk);
        tests_run++; if (if3.out_data_o !== 8'h10) begin tests_failed++; $display("FAIL bp_hold_data: got %h want 10", if3.out_data_o); end
        tests_run++; if (if3.in_ready_o !== 1'b0) begin tests_failed++; $display("FAIL bp_hold_ready: got %b want 0", if3.in_ready_o); end
        if3.out_ready_i = 1'b1;
        #1;
        tests_run++; if (if3.in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b want 1", if3.in_ready_o); end
        @(negedge clk);
        tests_run++; if (if3.out_data_o !== 8'h11) begin tests_failed++; $display("FAIL bp_out1: got %h want 11", if3.out_data_o); end
        tests_run++; if (if3.count_o !== 2'd3) begin tests_failed++; $display("FAIL bp_count_swap: got %0d want 3", if3.count_o); end
        if3.in_valid_i = 1'b0;
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b1 || if3.out_data_o !== 8'h12) begin tests_failed++; $display("FAIL bp_out2: got v=%b d=%h want v=1 d=12", if3.out_valid_o, if3.out_data_o); end
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b1 || if3.out_data_o !== 8'h13) begin tests_failed++; $display("FAIL bp_out3: got v=%b d=%h want v=1 d=13", if3.out_valid_o, if3.out_data_o); end
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b0 || if3.count_o !== 2'd0) begin tests_failed++; $display("FAIL bp_empty: got v=%b c=%0d want v=0 c=0", if3.out_valid_o, if3.count_o); end
    endtask

    task automatic test_bubble;
        @(negedge clk);
        if3.out_ready_i = 1'b0; if3.in_valid_i = 1'b1; if3.in_data_i = 8'hA0;
        @(negedge clk); if3.in_valid_i = 1'b0;
        @(negedge clk); if3.in_valid_i = 1'b1; if3.in_data_i = 8'hA1;
        #1;
        tests_run++; if (if3.in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL bub_ready_a1: got %b want 1", if3.in_ready_o); end
        @(negedge clk); if3.in_valid_i = 1'b0;
        #1;
        tests_run++; if (if3.in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL bub_ready_gap: got %b want 1", if3.in_ready_o); end
        @(negedge clk);
        tests_run++; if (if3.count_o !== 2'd2) begin tests_failed++; $display("FAIL bub_count: got %0d want 2", if3.count_o); end
        tests_run++; if (if3.out_data_o !== 8'hA0) begin tests_failed++; $display("FAIL bub_head: got %h want a0", if3.out_data_o); end
        if3.in_valid_i = 1'b1; if3.in_data_i = 8'hA2;
        #1;
        tests_run++; if (if3.in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL bub_ready_fill: got %b want 1", if3.in_ready_o); end
        @(negedge clk); if3.in_valid_i = 1'b0;
        #1;
        tests_run++; if (if3.in_ready_o !== 1'b0 || if3.count_o !== 2'd3) begin tests_failed++; $display("FAIL bub_full: got r=%b c=%0d want r=0 c=3", if3.in_ready_o, if3.count_o); end
        if3.out_ready_i = 1'b1;
        @(negedge clk);
        tests_run++; if (if3.out_data_o !== 8'hA1) begin tests_failed++; $display("FAIL bub_out1: got %h want a1", if3.out_data_o); end
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b1 || if3.out_data_o !== 8'hA2) begin tests_failed++; $display("FAIL bub_out2: got v=%b d=%h want v=1 d=a2", if3.out_valid_o, if3.out_data_o); end
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b0 || if3.count_o !== 2'd0) begin tests_failed++; $display("FAIL bub_empty: got v=%b c=%0d want v=0 c=0", if3.out_valid_o, if3.count_o); end
    endtask

    task automatic test_flush;
        @(negedge clk);
        if3.out_ready_i = 1'b0; if3.in_valid_i = 1'b1; if3.in_data_i = 8'h31;
        @(negedge clk); if3.in_data_i = 8'h32;
        @(negedge clk); if3.in_data_i = 8'h33;
        @(negedge clk);
        tests_run++; if (if3.count_o !== 2'd3) begin tests_failed++; $display("FAIL fl_loaded: got %0d want 3", if3.count_o); end
        if3.out_ready_i = 1'b1; if3.flush_i = 1'b1; if3.in_data_i = 8'h55;
        #1;
        tests_run++; if (if3.in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL fl_ready: got %b want 1", if3.in_ready_o); end
        @(negedge clk);
        if3.flush_i = 1'b0; if3.in_valid_i = 1'b0;
        tests_run++; if (if3.count_o !== 2'd0) begin tests_failed++; $display("FAIL fl_count: got %0d want 0", if3.count_o); end
        tests_run++; if (if3.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL fl_valid: got %b want 0", if3.out_valid_o); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++; if (if3.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL fl_no55_%0d: got v=%b d=%h want v=0", i, if3.out_valid_o, if3.out_data_o); end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        if3.out_ready_i = 1'b0; if3.in_valid_i = 1'b1; if3.in_data_i = 8'h71;
        @(negedge clk); if3.in_data_i = 8'h72;
        @(negedge clk); if3.in_valid_i = 1'b0;
        tests_run++; if (if3.count_o !== 2'd2) begin tests_failed++; $display("FAIL ar_pre_count: got %0d want 2", if3.count_o); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (if3.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ar_valid: got %b want 0", if3.out_valid_o); end
        tests_run++; if (if3.count_o !== 2'd0) begin tests_failed++; $display("FAIL ar_count: got %0d want 0", if3.count_o); end
        tests_run++; if (if3.in_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ar_ready: got %b want 1", if3.in_ready_o); end
        @(negedge clk);
        rst_n = 1'b1; if3.out_ready_i = 1'b1;
        @(negedge clk); if3.in_valid_i = 1'b1; if3.in_data_i = 8'h77;
        @(negedge clk); if3.in_valid_i = 1'b0;
        tests_run++; if (if3.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ar_e1: got %b want 0", if3.out_valid_o); end
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ar_e2: got %b want 0", if3.out_valid_o); end
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b1 || if3.out_data_o !== 8'h77) begin tests_failed++; $display("FAIL ar_e3: got v=%b d=%h want v=1 d=77", if3.out_valid_o, if3.out_data_o); end
        @(negedge clk);
        tests_run++; if (if3.out_valid_o !== 1'b0 || if3.count_o !== 2'd0) begin tests_failed++; $display("FAIL ar_e4: got v=%b c=%0d want v=0 c=0", if3.out_valid_o, if3.count_o); end
    endtask

    task automatic test_sweep;
        logic [31:0] q1[$];
        logic [31:0] q8[$];
        void'($urandom(32'd20240611));
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            tests_run++; if (if1.count_o !== q1.size()) begin tests_failed++; $display("FAIL sw1_count@%0d: got %0d want %0d", i, if1.count_o, q1.size()); end
            tests_run++; if (if8.count_o !== q8.size()) begin tests_failed++; $display("FAIL sw8_count@%0d: got %0d want %0d", i, if8.count_o, q8.size()); end
            if (i < 380) begin
                if1.in_valid_i = 1'($urandom_range(0, 1)); if1.out_ready_i = 1'($urandom_range(0, 1));
                if8.in_valid_i = 1'($urandom_range(0, 1)); if8.out_ready_i = ($urandom_range(0, 3) == 0);
                if1.in_data_i = $urandom; if8.in_data_i = $urandom;
            end else begin
                if1.in_valid_i = 1'b0; if1.out_ready_i = 1'b1;
                if8.in_valid_i = 1'b0; if8.out_ready_i = 1'b1;
            end
            #1;
            if (if1.in_valid_i && if1.in_ready_o) q1.push_back(if1.in_data_i);
            if (if8.in_valid_i && if8.in_ready_o) q8.push_back(if8.in_data_i);
            if (if1.out_valid_o && if1.out_ready_i) begin
                tests_run++;
                if (q1.size() == 0 || if1.out_data_o !== q1[0]) begin tests_failed++; $display("FAIL sw1_data@%0d: got %h want %h (queued %0d)", i, if1.out_data_o, (q1.size() != 0) ? q1[0] : 32'h0, q1.size()); end
                if (q1.size() != 0) void'(q1.pop_front());
            end
            if (if8.out_valid_o && if8.out_ready_i) begin
                tests_run++;
                if (q8.size() == 0 || if8.out_data_o !== q8[0]) begin tests_failed++; $display("FAIL sw8_data@%0d: got %h want %h (queued %0d)", i, if8.out_data_o, (q8.size() != 0) ? q8[0] : 32'h0, q8.size()); end
                if (q8.size() != 0) void'(q8.pop_front());
            end
        end
        tests_run++; if (q1.size() != 0 || q8.size() != 0) begin tests_failed++; $display("FAIL sw_drain: got q1=%0d q8=%0d want 0/0", q1.size(), q8.size()); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0;
        if3.in_data_i = '0; if3.in_valid_i = 1'b0; if3.out_ready_i = 1'b0; if3.flush_i = 1'b0;
        if1.in_data_i = '0; if1.in_valid_i = 1'b0; if1.out_ready_i = 1'b0; if1.flush_i = 1'b0;
        if8.in_data_i = '0; if8.in_valid_i = 1'b0; if8.out_ready_i = 1'b0; if8.flush_i = 1'b0;
        test_reset();
        test_latency();
        test_backpressure();
        test_bubble();
        test_flush();
        test_async_reset();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
